mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
- Serialises requests and inserts the fixed memory read latency.
- Returns read data with a one-cycle ack pulse and drives per-port stall signals that freeze the pipeline stages while an access is outstanding.
- Sits between the pipeline core and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset, sampled on the rising clk edge) despite the _n suffix.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req=1.
- if_rdata  out  DATA_W  fetch data; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data; valid when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  one-cycle command strobe to memory.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  freeze IF stage.
- stall_dm  out  1  freeze MEM stage.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. A CNT_W=4 latency counter and a grant register (IF/DM) accompany the FSM.
- Reset: state=IDLE, cnt=0, grant=IF. All registered outputs (if_rdata, dm_rdata, if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata) = 0. stall_if = stall_dm = 0 while rst_n=1.
- IDLE:
  - If dm_req, grant=DM (fixed DM priority, since the older instruction must win).
  - Else if if_req, grant=IF.
  - Latch the granted port's addr, we, and wdata (IF: we=0) into the mem_* registers and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): mem_en=1 and mem_we=latched we; mem_addr/mem_wdata held. cnt=1.
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT: mem_en=0. cnt increments each cycle. In the cycle where cnt==MEM_LAT, capture mem_rdata into the granted port's rdata register and go to DONE.
- DONE (1 cycle): the granted port's ack=1. No new grant is made in DONE; this prevents re-issuing a request that is still high in its ack cycle. Next state is IDLE.
- Latency:
  - Read request first seen at cycle T: mem_en at T+1, ack at T+MEM_LAT+2.
  - Write: mem_en at T+1, ack at T+2.
  - Back-to-back: with ack at cycle A, the next issue is at A+2.
- dm_rdata is not updated on writes; it holds its previous value. The non-granted port's rdata is never modified.
- mem_addr, mem_wdata, and mem_we hold their last values when mem_en=0.
- stall_if = if_req & ~if_ack; stall_dm = dm_req & ~dm_ack. These are combinational, and both are forced to 0 while rst_n=1.
- Simultaneous requests in IDLE: DM is served first. IF is served at the next IDLE and stalls meanwhile.
- Request dropped mid-transaction (protocol violation): the transaction completes and ack still pulses; no abort.
- Inputs changing while not granted: ignored. The latched copy is used for the granted transaction.
- Reset mid-transaction: FSM returns to IDLE and the in-flight access is abandoned. No ack is generated and late mem_rdata is ignored.

Test Plan:
- rst_n=1 for 2 cycles with if_req=dm_req=1 -> all outputs 0 during and the cycle after reset; first mem_en 2 cycles after rst_n falls.
- MEM_LAT=2, IF read if_addr=0x0000_0040, memory returns 0x2002_0005 -> mem_en=1/mem_we=0/mem_addr=0x40 at T+1; if_ack=1 with if_rdata=0x2002_0005 at T+4; stall_if=1 for T..T+3.
- if_req (0x40) and dm_req read (0x200, mem 0x0000_00AA) both at T -> DM issue T+1, dm_ack at T+4 with 0xAA; IF issue T+6, if_ack at T+9; stall_if high T..T+8.
- DM write addr 0x100, wdata 0xDEADBEEF at T -> mem_en=mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF at T+1; dm_ack at T+2; dm_rdata unchanged.
- IF read issued at T+1, rst_n=1 at T+2 -> outputs 0 at T+3; no if_ack ever; a fresh read after reset completes with normal latency.
- IF reads 0x40 then 0x44, with if_req held continuously -> exactly one mem_en per address; second mem_en at ack+2; MEM_LAT=1 variant gives ack at T+3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction-fetch (IF) and data (DM) ports.
// Requests are serialised with fixed DM priority. The fixed read latency is counted out in WAIT.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             dm_ack_q, dm_ack_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        // DM wins ties: it belongs to the older instruction in the pipeline.
        if (dm_req) begin
          grant_d     = GRANT_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ISSUE;
        end else if (if_req) begin
          grant_d    = GRANT_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = CNT_W'(1);
        if (mem_we_q) begin
          dm_ack_d = (grant_q == GRANT_DM);
          if_ack_d = (grant_q == GRANT_IF);
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          if (grant_q == GRANT_DM) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // No grant here: the finishing requester may still hold req during its ack cycle.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= GRANT_IF;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The reset input is active-high despite its name.
  assign stall_if = ~rst_n & if_req & ~if_ack_q;
  assign stall_dm = ~rst_n & dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios, then randomized IF/DM traffic.
// A queue scoreboard and a protocol monitor check the randomized traffic.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, stall_if, stall_dm;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_if_req, l1_if_ack, l1_dm_req, l1_dm_we, l1_dm_ack;
  logic [31:0] l1_if_addr, l1_if_rdata, l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
  logic        l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_dm;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_ack(l1_dm_ack),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
    .stall_if(l1_stall_if), .stall_dm(l1_stall_dm)
  );

  // ---------------- memory models ----------------
  bit          wr_flag [256];
  logic [31:0] wr_data [256];
  bit          p0_v, p1_v;
  logic [31:0] p0_d, p1_d;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      'h10:    return 32'h2002_0005;
      'h11:    return 32'h5555_6666;
      'h20:    return 32'h1111_2222;
      'h21:    return 32'h3333_4444;
      'h80:    return 32'h0000_00AA;
      default: return (32'(idx) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endcase
  endfunction

  function automatic logic [31:0] mem_val(input int idx);
    if (wr_flag[idx]) return wr_data[idx];
    return init_word(idx);
  endfunction

  // Read data is valid exactly LAT cycles after the command; junk otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_flag[mem_addr[9:2]] <= 1'b1;
      wr_data[mem_addr[9:2]] <= mem_wdata;
    end
    p0_v <= mem_en && !mem_we;
    p0_d <= mem_val(int'(mem_addr[9:2]));
    p1_v <= p0_v;
    p1_d <= p0_d;
  end
  assign mem_rdata = p1_v ? p1_d : {16'hBAD0, cyc[15:0]};

  always @(posedge clk)
    l1_mem_rdata <= (l1_mem_en && !l1_mem_we) ? (l1_mem_addr ^ 32'hCAFE_0000) : 32'hFFFF_FFFF;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // ---------------- directed observation window ----------------
  logic [15:0] en_m, ia_m, da_m, si_m, sd_m;
  logic [31:0] o_addr [16];
  logic [31:0] o_wd   [16];
  logic        o_we   [16];
  logic [31:0] o_ird  [16];
  logic [31:0] o_drd  [16];

  // Starts in cycle k=0 (inputs already driven); requesters drop req after their ack.
  // With chain set, the first IF ack moves if_addr to 0x44 and keeps if_req high.
  task automatic observe(input int n, input bit chain);
    bit chained;
    chained = 1'b0;
    en_m = '0; ia_m = '0; da_m = '0; si_m = '0; sd_m = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en_m[k] = mem_en;  ia_m[k] = if_ack;  da_m[k] = dm_ack;
      si_m[k] = stall_if; sd_m[k] = stall_dm;
      o_addr[k] = mem_addr; o_wd[k] = mem_wdata; o_we[k] = mem_we;
      o_ird[k] = if_rdata; o_drd[k] = dm_rdata;
      @(posedge clk); #1;
      if (ia_m[k]) begin
        if (chain && !chained) begin
          if_addr = 32'h44;
          chained = 1'b1;
        end else begin
          if_req = 1'b0;
        end
      end
      if (da_m[k]) dm_req = 1'b0;
    end
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t if_q [$];
  exp_t dm_q [$];
  logic [31:0] dm_ref [256];
  logic [31:0] dm_last;
  bit          sb_on = 1'b0;
  bit          outst = 1'b0;
  logic        en_port, en_we;
  int          en_cyc;
  logic        p_dm_req, p_dm_we, p_if_req;
  logic [31:0] p_dm_addr, p_dm_wdata, p_if_addr;

  always @(negedge clk) begin
    exp_t e;
    if (sb_on) begin
      if (mem_en) begin
        check("cmd_overlap", 32'(outst), 32'd0);
        outst   = 1'b1;
        en_port = p_dm_req;
        en_we   = mem_we;
        en_cyc  = cyc;
        if (p_dm_req) begin
          check("dm_cmd_addr", mem_addr, p_dm_addr);
          check("dm_cmd_we", 32'(mem_we), 32'(p_dm_we));
          if (p_dm_we) check("dm_cmd_wdata", mem_wdata, p_dm_wdata);
        end else begin
          check("if_cmd_req", 32'(p_if_req), 32'd1);
          check("if_cmd_addr", mem_addr, p_if_addr);
          check("if_cmd_we", 32'(mem_we), 32'd0);
        end
      end
      if (if_ack || dm_ack) begin
        check("ack_both", 32'(if_ack && dm_ack), 32'd0);
        check("ack_outstanding", 32'(outst), 32'd1);
        check("ack_port", 32'(dm_ack), 32'(en_port));
        check("ack_latency", 32'(cyc - en_cyc), en_we ? 32'd1 : 32'(LAT + 1));
        outst = 1'b0;
        if (if_ack) begin
          if (if_q.size() == 0) fail_now("if_ack_unexpected");
          else begin
            e = if_q.pop_front();
            check("if_rdata", if_rdata, e.data);
          end
        end
        if (dm_ack) begin
          if (dm_q.size() == 0) fail_now("dm_ack_unexpected");
          else begin
            e = dm_q.pop_front();
            check(e.wr ? "dm_rdata_hold" : "dm_rdata", dm_rdata, e.data);
          end
        end
      end
      check("stall_if", 32'(stall_if), 32'(if_req & ~if_ack));
      check("stall_dm", 32'(stall_dm), 32'(dm_req & ~dm_ack));
    end
    p_dm_req = dm_req; p_dm_we = dm_we; p_dm_addr = dm_addr; p_dm_wdata = dm_wdata;
    p_if_req = if_req; p_if_addr = if_addr;
  end

  // ---------------- random drivers ----------------
  task automatic if_drv(input int n);
    for (int i = 0; i < n; i++) begin
      int g, idx, t;
      g   = $urandom_range(0, 3);
      idx = $urandom_range(0, 63);
      repeat (g) begin @(posedge clk); #1; end
      if_addr = 32'(idx) << 2;
      if_q.push_back('{wr: 1'b0, data: mem_val(idx)});
      if_req = 1'b1;
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (if_ack) break;
      end
      if (t == 200) fail_now("if_ack_timeout");
      @(posedge clk); #1;
      if_req = 1'b0;
    end
  endtask

  task automatic dm_drv(input int n);
    for (int i = 0; i < n; i++) begin
      int g, idx, t;
      logic we;
      logic [31:0] wd;
      g   = $urandom_range(0, 3);
      idx = 64 + $urandom_range(0, 63);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      repeat (g) begin @(posedge clk); #1; end
      if (we) begin
        dm_q.push_back('{wr: 1'b1, data: dm_last});
        dm_ref[idx] = wd;
      end else begin
        dm_q.push_back('{wr: 1'b0, data: dm_ref[idx]});
        dm_last = dm_ref[idx];
      end
      dm_we    = we;
      dm_addr  = 32'(idx) << 2;
      dm_wdata = wd;
      dm_req   = 1'b1;
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (dm_ack) break;
      end
      if (t == 200) fail_now("dm_ack_timeout");
      @(posedge clk); #1;
      dm_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] l1_ack_m, l1_en_m;
    logic [31:0] l1_rd3;

    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0;
    l1_if_req = 1'b0; l1_if_addr = 32'h0;
    l1_dm_req = 1'b0; l1_dm_we = 1'b0; l1_dm_addr = 32'h0; l1_dm_wdata = 32'h0;

    // Reset held for two edges with both requests high.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ctrl_outs", {25'd0, mem_en, mem_we, if_ack, dm_ack, stall_if, stall_dm, 1'b0},
          32'd0);
    check("rst_rdata", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Simultaneous DM read 0x200 and IF read 0x40 right out of reset.
    observe(12, 1'b0);
    check("A_k0_rdata", o_ird[0] | o_drd[0] | o_addr[0], 32'd0);
    check("A_en_mask", 32'(en_m[11:0]), 32'h042);
    check("A_dm_cmd_addr", o_addr[1], 32'h200);
    check("A_dm_ack_mask", 32'(da_m[11:0]), 32'h010);
    check("A_dm_rdata", o_drd[4], 32'h0000_00AA);
    check("A_if_cmd_addr", o_addr[6], 32'h40);
    check("A_if_ack_mask", 32'(ia_m[11:0]), 32'h200);
    check("A_if_rdata", o_ird[9], 32'h2002_0005);
    check("A_stall_if", 32'(si_m[11:0]), 32'h1FF);
    check("A_stall_dm", 32'(sd_m[11:0]), 32'h00F);

    // Lone IF read.
    if_addr = 32'h40; if_req = 1'b1;
    observe(8, 1'b0);
    check("B_en_mask", 32'(en_m[7:0]), 32'h02);
    check("B_cmd", {o_addr[1][30:0], o_we[1]}, {31'h40, 1'b0});
    check("B_if_ack_mask", 32'(ia_m[7:0]), 32'h10);
    check("B_if_rdata", o_ird[4], 32'h2002_0005);
    check("B_stall_if", 32'(si_m[7:0]), 32'h0F);

    // DM write leaves dm_rdata alone.
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    observe(5, 1'b0);
    check("C_en_mask", 32'(en_m[4:0]), 32'h02);
    check("C_cmd_we", 32'(o_we[1]), 32'd1);
    check("C_cmd_addr", o_addr[1], 32'h100);
    check("C_cmd_wdata", o_wd[1], 32'hDEAD_BEEF);
    check("C_dm_ack_mask", 32'(da_m[4:0]), 32'h04);
    check("C_dm_rdata_hold", o_drd[2], 32'h0000_00AA);
    check("C_mem_written", mem_val(64), 32'hDEAD_BEEF);
    dm_we = 1'b0;

    // Reset lands during an IF read; a fresh read follows.
    if_addr = 32'h80; if_req = 1'b1;
    observe(2, 1'b0);
    check("D_first_cmd", {31'(en_m[1:0]), 1'b0}, 32'h4);
    rst_n = 1'b1;
    if_addr = 32'h84;
    @(posedge clk); #1;
    rst_n = 1'b0;
    observe(7, 1'b0);
    check("D_k0_outs", o_ird[0] | {31'd0, ia_m[0]}, 32'd0);
    check("D_en_mask", 32'(en_m[6:0]), 32'h02);
    check("D_cmd_addr", o_addr[1], 32'h84);
    check("D_if_ack_mask", 32'(ia_m[6:0]), 32'h10);
    check("D_if_rdata", o_ird[4], 32'h3333_4444);

    // Back-to-back IF reads with if_req held across the ack.
    if_addr = 32'h40; if_req = 1'b1;
    observe(11, 1'b1);
    check("E_en_mask", 32'(en_m[10:0]), 32'h042);
    check("E_addr0", o_addr[1], 32'h40);
    check("E_addr1", o_addr[6], 32'h44);
    check("E_if_ack_mask", 32'(ia_m[10:0]), 32'h210);
    check("E_if_rdata0", o_ird[4], 32'h2002_0005);
    check("E_if_rdata1", o_ird[9], 32'h5555_6666);

    // MEM_LAT=1 instance: ack three cycles after the request.
    l1_if_addr = 32'h40; l1_if_req = 1'b1;
    l1_ack_m = '0; l1_en_m = '0; l1_rd3 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      l1_ack_m[k] = l1_if_ack;
      l1_en_m[k]  = l1_mem_en;
      if (k == 3) l1_rd3 = l1_if_rdata;
      @(posedge clk); #1;
      if (l1_ack_m[k]) l1_if_req = 1'b0;
    end
    check("F_l1_en_mask", 32'(l1_en_m), 32'h02);
    check("F_l1_ack_mask", 32'(l1_ack_m), 32'h08);
    check("F_l1_rdata", l1_rd3, 32'hCAFE_0040);

    // Randomized traffic against the scoreboard.
    if_req = 1'b0; dm_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    dm_last = 32'd0;
    for (int i = 0; i < 256; i++) dm_ref[i] = mem_val(i);
    sb_on = 1'b1;
    fork
      if_drv(40);
      dm_drv(40);
    join
    repeat (10) @(posedge clk);
    #1;
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("dm_q_drained", 32'(dm_q.size()), 32'd0);
    check("none_outstanding", 32'(outst), 32'd0);
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
